if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction fetch stage. Owns the PC, issues in-order word fetches to instruction memory and
//  buffers returned words in a small FIFO. Presents the head instruction and its split fields
//  (op/rs/rt/rd/shamt/funct/imm16/index26) to decode. id_imm16 feeds the immediate extender
//  directly. Redirects from branch/jump resolution flush all fetched and in-flight words.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC loaded on reset
//  BUF_DEPTH   2              instruction buffer entries; also max outstanding fetches (>=1)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch address (= pc, bits[1:0]=0)
//  imem_gnt        in   1   request accepted this cycle (req&&gnt = handshake)
//  imem_rvalid     in   1   response valid, in request order, >=1 cycle after grant
//  imem_rdata      in   32  response instruction word
//  redirect_valid  in   1   redirect fetch to redirect_pc (branch/jump taken)
//  redirect_pc     in   32  new PC; bits[1:0] ignored, forced to 0
//  id_ready        in   1   decode accepts head this cycle (0 = stall)
//  id_valid        out  1   head entry valid
//  id_pc           out  32  PC of head instruction
//  id_instr        out  32  head instruction word
//  id_op/id_funct  out  6   instr[31:26] / instr[5:0]
//  id_rs/rt/rd     out  5   instr[25:21] / [20:16] / [15:11]
//  id_shamt        out  5   instr[10:6]
//  id_imm16        out  16  instr[15:0]
//  id_index26      out  26  instr[25:0]
// BEHAVIOUR
//  - Reset: pc=RESET_PC; buffer empty; outstanding=0; drop=0; id_valid=0; all id_* data=0;
//    imem_req=0 in the reset cycle. A reset mid-operation discards everything, incl. later
//    responses to pre-reset requests (drop counter loaded with outstanding).
//  - Credit: imem_req = !rst && !redirect_valid && (count + outstanding < BUF_DEPTH).
//  - On req&&gnt: pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
//  - On rvalid: outstanding--; if drop>0 then drop-- and word discarded, else push
//    {pc_of_request, rdata}. Per-request PC tracked in a BUF_DEPTH-deep PC queue.
//  - Head: id_valid = count!=0; id_* driven combinationally from buffer head. Pop on
//    id_valid&&id_ready. Push+pop same cycle legal at any occupancy, count unchanged.
//  - Latency: grant at T, rvalid at T+k -> id_valid at T+k+1 (registered buffer, no bypass).
//  - id_* data must hold stable while id_valid && !id_ready.
//  - Redirect (highest priority): pc <= {redirect_pc[31:2],2'b00}; buffer emptied;
//    drop <= outstanding minus any rvalid in the same cycle; no request that cycle;
//    id_valid=0 next cycle. An rvalid in the redirect cycle is discarded. Pop in the redirect
//    cycle is still a valid consumption of the old head.
//  - Overflow impossible by credit; assertion: push never occurs with count==BUF_DEPTH.
//  - Underflow: id_ready with id_valid=0 is a no-op.
// STRUCTURE
//  - mips_pkg: RESET_PC default, instruction field bit positions (OP_HI/LO, RS_*, RT_*, RD_*,
//    SHAMT_*, FUNCT_*, IMM_*, INDEX_*), word width constants.
//  - Sub-module if_buf: sync FIFO (width 64 = pc+instr, depth BUF_DEPTH) with push, pop,
//    flush, count, show-ahead head. PC/credit/drop logic and field split stay in if_stage.
// TESTING
//  1 Reset, gnt=1, rvalid 1-cycle after grant, id_ready=1 -> imem_addr 0x3000,0x3004,...;
//    first id_valid 2 cycles after first grant; id_pc=0x3000.
//  2 rdata=32'h2008FFFF at 0x3000 -> id_op=6'h08, id_rs=0, id_rt=8, id_imm16=16'hFFFF,
//    id_index26=26'h008FFFF.
//  3 id_ready=0 for 6 cycles -> at most BUF_DEPTH words buffered, imem_req drops, id_* stable;
//    release -> in-order delivery, no loss or duplication.
//  4 Two fetches in flight, redirect_pc=0x3101 -> both responses dropped, next imem_addr
//    0x3100, next id_pc 0x3100.
//  5 Redirect in same cycle as rvalid and pop -> returning word discarded, old head consumed once.
//  6 RESET_PC=32'hFFFF_FFF8 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; rst mid-run
//    with 1 outstanding -> late rvalid ignored, restart at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS fetch definitions: reset PC, word widths, instruction field positions
// and the buffered fetch entry layout.
package mips_pkg;
   localparam int WORD_W  = 32;
   localparam int ENTRY_W = 2 * WORD_W;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int SHAMT_HI = 10;
   localparam int SHAMT_LO = 6;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int INDEX_HI = 25;
   localparam int INDEX_LO = 0;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_stage_if.sv
// Bundle of the instruction-memory handshake and the decode-facing head outputs.
// master = fetch stage side, slave = memory/decode side.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [5:0]  id_op;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [4:0]  id_shamt;
   logic [15:0] id_imm16;
   logic [25:0] id_index26;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  id_ready,
      output id_valid, id_pc, id_instr, id_op, id_funct,
      output id_rs, id_rt, id_rd, id_shamt, id_imm16, id_index26
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output id_ready,
      input  id_valid, id_pc, id_instr, id_op, id_funct,
      input  id_rs, id_rt, id_rd, id_shamt, id_imm16, id_index26
   );
endinterface

// File: rtl/if_buf.sv
// Synchronous show-ahead FIFO with flush. head reads as zero while empty so the
// decode-facing data is clean after reset or a flush.
module if_buf #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [CW-1:0]    cnt_r;
   logic             pop_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return {PW{1'b0}};
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Popping an empty buffer is a no-op.
   assign pop_s = pop && (cnt_r != {CW{1'b0}});
   assign head  = (cnt_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
   assign count = cnt_r;

   // Pointer, occupancy and storage update.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1);
            2'b01:   cnt_r <= cnt_r - CW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   if_buf_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .count (cnt_r)
   );
endmodule

// File: rtl/if_buf_chk.sv
// Occupancy checker for if_buf: a push must never land on a full buffer.
module if_buf_chk #(
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input logic          clk,
   input logic          rst,
   input logic          push,
   input logic [CW-1:0] count
);
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      push |-> (count != CW'(DEPTH)));
endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited in-order fetches, response drop after
// redirect/reset, and a show-ahead instruction buffer split into fields for decode.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input logic        clk,
   input logic        rst,
   input logic        redirect_valid,
   input logic [31:0] redirect_pc,
   if_stage_if.master bus
);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic [31:0]   pc_r;
   logic [CW-1:0] out_r;
   logic [CW-1:0] drop_r;
   logic [CW-1:0] buf_cnt_s;
   logic [CW-1:0] pcq_cnt_s;
   logic [CW-1:0] inflight_s;
   logic [CW+1:0] credit_s;
   logic [31:0]   req_pc_s;
   logic          req_s;
   logic          hs_s;
   logic          drop_hit_s;
   logic          live_rsp_s;
   logic          push_s;
   logic          pop_s;
   fetch_entry_t  push_entry_s;
   fetch_entry_t  head_s;

   // Dropped responses still hold credit, so memory never sees more than BUF_DEPTH in flight.
   always_comb begin
      credit_s     = {2'b00, buf_cnt_s} + {2'b00, out_r} + {2'b00, drop_r};
      req_s        = !rst && !redirect_valid && (credit_s < (CW+2)'(BUF_DEPTH));
      hs_s         = req_s && bus.imem_gnt;
      drop_hit_s   = bus.imem_rvalid && (drop_r != {CW{1'b0}});
      live_rsp_s   = bus.imem_rvalid && !drop_hit_s && (out_r != {CW{1'b0}});
      inflight_s   = out_r + drop_r - CW'(drop_hit_s) - CW'(live_rsp_s);
      push_s       = live_rsp_s && (pcq_cnt_s != {CW{1'b0}}) && !redirect_valid && !rst;
      pop_s        = (buf_cnt_s != {CW{1'b0}}) && bus.id_ready;
      push_entry_s = '{pc: req_pc_s, instr: bus.imem_rdata};
   end

   // Program counter: reset, then redirect, then advance on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= RESET_PC;
      end else if (redirect_valid) begin
         pc_r <= word_align(redirect_pc);
      end else if (hs_s) begin
         pc_r <= pc_r + 32'd4;
      end else begin
         pc_r <= pc_r;
      end
   end

   // A restart turns everything still in flight into responses to be discarded.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         out_r  <= {CW{1'b0}};
         drop_r <= inflight_s;
      end else begin
         out_r  <= out_r + CW'(hs_s) - CW'(live_rsp_s);
         drop_r <= drop_r - CW'(drop_hit_s);
      end
   end

   if_buf #(.DEPTH(BUF_DEPTH), .WIDTH(WORD_W), .CW(CW)) u_pcq (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (hs_s),
      .pop   (live_rsp_s),
      .wdata (pc_r),
      .head  (req_pc_s),
      .count (pcq_cnt_s)
   );

   if_buf #(.DEPTH(BUF_DEPTH), .WIDTH(ENTRY_W), .CW(CW)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (push_entry_s),
      .head  (head_s),
      .count (buf_cnt_s)
   );

   assign bus.imem_req   = req_s;
   assign bus.imem_addr  = pc_r;
   assign bus.id_valid   = (buf_cnt_s != {CW{1'b0}});
   assign bus.id_pc      = head_s.pc;
   assign bus.id_instr   = head_s.instr;
   assign bus.id_op      = head_s.instr[OP_HI:OP_LO];
   assign bus.id_rs      = head_s.instr[RS_HI:RS_LO];
   assign bus.id_rt      = head_s.instr[RT_HI:RT_LO];
   assign bus.id_rd      = head_s.instr[RD_HI:RD_LO];
   assign bus.id_shamt   = head_s.instr[SHAMT_HI:SHAMT_LO];
   assign bus.id_funct   = head_s.instr[FUNCT_HI:FUNCT_LO];
   assign bus.id_imm16   = head_s.instr[IMM_HI:IMM_LO];
   assign bus.id_index26 = head_s.instr[INDEX_HI:INDEX_LO];
endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: random memory/decode/redirect/reset traffic against a
// queue-level model of fetch, plus a second instance checking PC wrap from 0xFFFF_FFF8.
module tb_if_stage;
   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] addr;
      int unsigned ready_cyc;
      int          epoch;
   } req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        rst2;
   logic        redir2;
   logic [31:0] redir_pc2;

   if_stage_if bus ();
   if_stage_if bus2 ();

   if_stage #(.RESET_PC(32'h0000_3000), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .bus(bus)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst(rst2), .redirect_valid(redir2),
      .redirect_pc(redir_pc2), .bus(bus2)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   req_t        pend[$];
   ent_t        expq[$];
   logic [31:0] m_pc = 32'h0000_3000;
   int          epoch = 0;
   int unsigned cyc = 0;

   int p_gnt = 100, p_ready = 100, p_redir = 0, p_rst = 0, lat_max = 0;
   bit hold_rsp = 1'b0, rst_force = 1'b1, force_redir = 1'b0, want_t5 = 1'b0;
   logic [31:0] force_rp = 32'h0;
   int t5_hits = 0;
   bit hs2_last = 1'b0;
   logic [31:0] addrs2[$];
   logic [31:0] pcs2[$];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2008_FFFF;
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   // Driver: one cycle of inputs, applied at the falling edge.
   task automatic drive_cycle();
      logic rv;
      @(negedge clk);
      rv = (pend.size() != 0) && !hold_rsp;
      if (rv) rv = (pend[0].ready_cyc <= cyc);
      bus.imem_rvalid = rv;
      if (rv) bus.imem_rdata = memword(pend[0].addr);
      else    bus.imem_rdata = $urandom;
      bus.imem_gnt   = ($urandom_range(0, 99) < p_gnt);
      bus.id_ready   = ($urandom_range(0, 99) < p_ready);
      redirect_valid = ($urandom_range(0, 99) < p_redir);
      redirect_pc    = $urandom;
      rst            = rst_force || ($urandom_range(0, 999) < p_rst);
      if (force_redir) begin
         redirect_valid = 1'b1;
         redirect_pc    = force_rp;
         force_redir    = 1'b0;
      end
      if (want_t5 && rv && expq.size() != 0) begin
         redirect_valid = 1'b1;
         bus.id_ready   = 1'b1;
         want_t5        = 1'b0;
         t5_hits++;
      end
      bus2.imem_gnt    = 1'b1;
      bus2.imem_rvalid = hs2_last;
      bus2.imem_rdata  = 32'h0;
      bus2.id_ready    = 1'b1;
   endtask

   // Monitor: compares request and head outputs with the model, consumes on id_ready.
   always @(negedge clk) begin
      logic        exp_req;
      logic [31:0] w;
      #1;
      exp_req = !rst && !redirect_valid && ((expq.size() + pend.size()) < DEPTH);
      check("imem_req", bus.imem_req, exp_req);
      if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
      check("id_valid", bus.id_valid, expq.size() != 0);
      if (expq.size() != 0) begin
         w = expq[0].instr;
         check("id_pc", bus.id_pc, expq[0].pc);
         check("id_instr", bus.id_instr, w);
         if (bus.id_ready) begin
            check("fields",
                  {bus.id_op, bus.id_rs, bus.id_rt, bus.id_rd, bus.id_shamt, bus.id_funct,
                   bus.id_imm16, bus.id_index26},
                  {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], w[15:0], w[25:0]});
            if (expq[0].pc == 32'h0000_3000)
               check("t2_op_rt_imm", {bus.id_op, bus.id_rs, bus.id_rt, bus.id_imm16},
                     {6'h08, 5'd0, 5'd8, 16'hFFFF});
            void'(expq.pop_front());
         end
      end
   end

   // Reference model: what the upcoming rising edge does to memory and the expected stream.
   always @(negedge clk) begin
      req_t r;
      #2;
      if (bus.imem_rvalid && pend.size() != 0) begin
         r = pend.pop_front();
         if (!rst && !redirect_valid && r.epoch == epoch)
            expq.push_back('{pc: r.addr, instr: memword(r.addr)});
      end
      if (rst) begin
         epoch++;
         expq.delete();
         m_pc = 32'h0000_3000;
      end else if (redirect_valid) begin
         epoch++;
         expq.delete();
         m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (bus.imem_req && bus.imem_gnt) begin
         pend.push_back('{addr: m_pc,
                          ready_cyc: cyc + 1 + $urandom_range(0, lat_max),
                          epoch: epoch});
         m_pc = m_pc + 32'd4;
      end
      hs2_last = bus2.imem_req && !rst2;
      if (bus2.imem_req && !rst2 && addrs2.size() < 4) addrs2.push_back(bus2.imem_addr);
      if (bus2.id_valid && pcs2.size() < 4) pcs2.push_back(bus2.id_pc);
      cyc++;
   end

   task automatic run(input int n);
      for (int i = 0; i < n; i++) drive_cycle();
   endtask

   initial begin
      logic [31:0] wrap_exp [3];
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      rst = 1'b1; rst2 = 1'b1; redir2 = 1'b0; redir_pc2 = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0; bus.id_ready = 1'b0;
      bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = 32'h0; bus2.id_ready = 1'b0;

      run(2);
      rst_force = 1'b0;
      rst2 = 1'b0;
      drive_cycle();
      #3;
      check("rst_state", {bus.id_valid, bus.id_pc, bus.id_instr, bus.imem_addr},
            {1'b0, 32'h0, 32'h0, 32'h0000_3000});

      // Streaming with 1-cycle latency, then a 6-cycle decode stall.
      run(20);
      p_ready = 0;
      run(6);
      p_ready = 100;
      run(10);

      // Redirect to a misaligned target with two fetches in flight.
      hold_rsp = 1'b1;
      run(4);
      force_rp = 32'h0000_3101;
      force_redir = 1'b1;
      drive_cycle();
      hold_rsp = 1'b0;
      run(12);

      // Redirect coinciding with a returning word and a pop of the old head.
      p_ready = 30; p_gnt = 80; lat_max = 2; want_t5 = 1'b1;
      run(200);
      check("t5_reached", t5_hits, 1);

      // Reset with fetches outstanding; late responses must be ignored.
      p_ready = 100; p_gnt = 100; lat_max = 0;
      hold_rsp = 1'b1;
      run(3);
      rst_force = 1'b1;
      drive_cycle();
      rst_force = 1'b0;
      hold_rsp = 1'b0;
      run(15);

      // Random mix.
      p_gnt = 70; p_ready = 60; p_redir = 4; p_rst = 5; lat_max = 3;
      run(1500);

      // Drain.
      p_gnt = 0; p_ready = 100; p_redir = 0; p_rst = 0;
      run(20);
      check("drain_expq", expq.size(), 0);
      check("drain_pend", pend.size(), 0);

      check("wrap_addr_n", addrs2.size() >= 3, 1'b1);
      check("wrap_pc_n", pcs2.size() >= 3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i < addrs2.size()) check("wrap_addr", addrs2[i], wrap_exp[i]);
         if (i < pcs2.size())   check("wrap_id_pc", pcs2[i], wrap_exp[i]);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
